// File: rtl/audio_pkg.sv
// Shared framing constants for the WM8731 ADC receiver and DAC serializer.
// Slot offsets are counted in bit clocks from the adclrck pulse.
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_LEN   = 251;
  localparam int LEFT_FIRST  = 1;
  localparam int RIGHT_FIRST = SAMPLE_W + 1;
  localparam int PUSH_SLOT   = 2*SAMPLE_W + 1;
endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO of stereo frames with a registered head word.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int W     = 2*SAMPLE_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [W-1:0]            head_q, head_d;
  logic                    do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = head_q;

  // Next head: a push into an empty (or just-drained) FIFO bypasses the memory.
  always_comb begin
    rptr_d = rptr_q + (AW+1)'(do_pop);
    wptr_d = wptr_q + (AW+1)'(do_push);
    head_d = head_q;
    if (do_push && (rptr_d == wptr_q)) head_d = din_i;
    else if (rptr_d != wptr_d)         head_d = mem_q[rptr_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end
endmodule

// File: rtl/audio_adc_rx.sv
// WM8731 ADC receiver: drives the DSP-mode frame sync, deserializes left/right
// words MSB first and hands stereo frames to a consumer through a small FIFO.
module audio_adc_rx #(
  parameter int FRAME_LEN  = audio_pkg::FRAME_LEN,
  parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                adcdat,
  output logic                adclrck,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clear_overrun
);
  localparam int CW = $clog2(FRAME_LEN);
  // Package offsets are rebased so a non-default SAMPLE_W keeps the same slot layout.
  localparam int PKG_W    = audio_pkg::SAMPLE_W;
  localparam int LEFT_LO  = audio_pkg::LEFT_FIRST;
  localparam int RIGHT_LO = audio_pkg::RIGHT_FIRST - PKG_W + SAMPLE_W;
  localparam int PUSH_AT  = audio_pkg::PUSH_SLOT - 2*PKG_W + 2*SAMPLE_W;

  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
  logic                  ovr_q, ovr_d;
  logic                  in_left, in_right, push, pop, full, empty;
  logic [2*SAMPLE_W-1:0] head;

  assign in_left  = enable && (fcnt_q >= CW'(LEFT_LO))  && (fcnt_q < CW'(RIGHT_LO));
  assign in_right = enable && (fcnt_q >= CW'(RIGHT_LO)) && (fcnt_q < CW'(PUSH_AT));
  assign push     = enable && (fcnt_q == CW'(PUSH_AT));
  assign pop      = sample_ready && !empty;

  always_comb begin
    fcnt_d  = '0;
    left_d  = left_q;
    right_d = right_q;
    if (enable) fcnt_d = (fcnt_q == CW'(FRAME_LEN-1)) ? '0 : fcnt_q + 1'b1;
    if (in_left)  left_d  = {left_q[SAMPLE_W-2:0], adcdat};
    if (in_right) right_d = {right_q[SAMPLE_W-2:0], adcdat};
    // A new drop outranks a simultaneous clear.
    ovr_d = (push && full && !pop) || (ovr_q && !clear_overrun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      ovr_q   <= ovr_d;
    end
  end

  audio_sample_fifo #(.W(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({left_q, right_q}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign adclrck      = enable && reset_n && (fcnt_q == '0);
  assign sample_valid = !empty;
  assign sample_left  = head[2*SAMPLE_W-1:SAMPLE_W];
  assign sample_right = head[SAMPLE_W-1:0];
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: directed scenarios plus random frames, checked every
// cycle against a frame-level model (queue of stereo words, slot counter).
module tb_audio_adc_rx;
  localparam int FL = 251;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int PS = 2*W + 1;

  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, adcdat = 1'b0;
  logic          sample_ready = 1'b0, clear_overrun = 1'b0;
  logic          adclrck, sample_valid, overrun;
  logic [W-1:0]  sample_left, sample_right;

  int            nchk = 0, nerr = 0;
  logic [31:0]   mq[$];
  logic [31:0]   plan[$];
  logic [31:0]   fr;
  bit            m_ovr;
  int            mf;

  always #5 clk = ~clk;

  audio_adc_rx #(.FRAME_LEN(FL), .SAMPLE_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adcdat(adcdat),
    .adclrck(adclrck), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pick();
    if (plan.size() > 0) fr = plan.pop_front();
    else fr = $urandom;
  endtask

  task automatic drive();
    if (mf >= 1 && mf <= 2*W) adcdat = fr[2*W-mf];
    else adcdat = 1'($urandom);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit en, rdy, clr, set;
    int prev;
    en  = enable;
    rdy = sample_ready;
    clr = clear_overrun;
    @(posedge clk); #1;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    set = 1'b0;
    if (en && mf == PS) begin
      if (mq.size() == D) set = 1'b1;
      else mq.push_back(fr);
    end
    m_ovr = set || (m_ovr && !clr);
    prev  = mf;
    mf    = en ? ((mf == FL-1) ? 0 : mf + 1) : 0;
    if (mf == 0 && prev != 0) pick();
    chk("adclrck", 64'(adclrck), 64'(enable && mf == 0));
    chk("valid",   64'(sample_valid), 64'(mq.size() > 0));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    if (mq.size() > 0) chk("head", 64'({sample_left, sample_right}), 64'(mq[0]));
    drive();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    do begin step(); n++; end while (mf != target && n < 2*FL);
    chk("run_to", 64'(mf), 64'(target));
  endtask

  task automatic pop1();
    sample_ready = 1'b1; step(); sample_ready = 1'b0;
  endtask

  initial begin
    // Reset held with adcdat toggling
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      adcdat = ~adcdat;
      chk("rst_outs", 64'({adclrck, sample_valid, overrun, sample_left, sample_right}), 64'd0);
    end
    plan.push_back(32'hA5C3_0F81);
    mf = 0; m_ovr = 1'b0; pick();
    reset_n = 1'b1; #1;
    chk("lrck_first", 64'(adclrck), 64'd1);
    drive();

    // Single frame and its latency
    run_to(PS);
    chk("lat_pre", 64'(sample_valid), 64'd0);
    step();
    chk("lat_valid", 64'(sample_valid), 64'd1);
    chk("single_l", 64'(sample_left), 64'h0000_0000_0000_A5C3);
    chk("single_r", 64'(sample_right), 64'h0000_0000_0000_0F81);
    pop1();
    chk("drop_valid", 64'(sample_valid), 64'd0);

    // Backpressure over three frames
    plan.push_back(32'h0001_0001); plan.push_back(32'h0002_0002); plan.push_back(32'h0003_0003);
    for (int f = 0; f < 3; f++) run_to(PS + 1);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("bp_head1", 64'({sample_left, sample_right}), 64'h0001_0001);
    pop1();
    chk("bp_head2", 64'({sample_left, sample_right}), 64'h0002_0002);
    pop1();
    chk("bp_empty", 64'(sample_valid), 64'd0);
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'd0);

    // Full FIFO with a pop exactly at the push edge
    plan.push_back(32'h0004_0004); plan.push_back(32'h0005_0005); plan.push_back(32'h0006_0006);
    run_to(PS + 1);
    run_to(PS + 1);
    run_to(PS);
    pop1();
    chk("fp_ovr", 64'(overrun), 64'd0);
    chk("fp_head", 64'({sample_left, sample_right}), 64'h0005_0005);
    pop1();
    chk("fp_tail", 64'({sample_left, sample_right}), 64'h0006_0006);
    pop1();

    // Mid-frame disable at fcnt=10, then re-enable
    plan.push_back(32'h0007_0007); plan.push_back(32'h0099_0099); plan.push_back(32'h0008_0008);
    run_to(PS + 1);
    run_to(10);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("dis_lrck", 64'(adclrck), 64'd0);
    chk("dis_keep", 64'({sample_valid, sample_left, sample_right}), 64'h1_0007_0007);
    enable = 1'b1; #1;
    chk("reen_lrck", 64'(adclrck), 64'd1);
    run_to(PS + 1);
    chk("reen_head", 64'({sample_left, sample_right}), 64'h0007_0007);
    pop1();
    chk("reen_frame", 64'({sample_left, sample_right}), 64'h0008_0008);

    // Asynchronous reset mid-frame with one frame buffered
    run_to(20);
    reset_n = 1'b0; #2;
    chk("arst_outs", 64'({adclrck, sample_valid, overrun, sample_left, sample_right}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    mq.delete(); m_ovr = 1'b0; mf = 0; pick(); drive(); #1;
    chk("arst_empty", 64'({sample_valid, overrun}), 64'd0);

    // Random consumer behaviour over several frames
    for (int i = 0; i < 5*FL; i++) begin
      sample_ready  = ($urandom_range(0, 7) == 0);
      clear_overrun = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
